// File: rtl/math_pkg.sv
// Shared arithmetic constants and types for the Goldilocks-field NTT datapath.
package math_pkg;

  localparam int PIPE_DEPTH_MULRED      = 10;
  localparam int PIPE_DEPTH_BFLY_ADDSUB = 3;
  localparam logic [63:0] P_GOLDILOCKS  = 64'hFFFF_FFFF_0000_0001;

  typedef struct packed {
    logic [64:0] s;
    logic [64:0] d;
  } sumdiff_t;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/modcanon.sv
// Single conditional subtraction bringing any 64-bit value into [0, P).
module modcanon
  import math_pkg::*;
(
  input  logic [63:0] a,
  output logic [63:0] y
);

  assign y = (a >= P_GOLDILOCKS) ? a - P_GOLDILOCKS : a;

endmodule

// File: rtl/bfly_addsub.sv
// Butterfly add/sub stage: aligns x with the delayed multiplier product t and
// produces (x+t) mod P and (x-t) mod P, with frame tagging on the output.
module bfly_addsub
  import math_pkg::*;
#(
  parameter int DELAY  = PIPE_DEPTH_MULRED,
  parameter int N_BFLY = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ce_i,
  input  logic        valid_i,
  input  logic [63:0] x_i,
  input  logic [63:0] t_i,
  output logic [63:0] y0_o,
  output logic [63:0] y1_o,
  output logic        valid_o,
  output logic        last_o
);

  localparam int CW = cnt_width(N_BFLY);
  localparam logic [CW-1:0] CNT_LAST = CW'(N_BFLY - 1);
  localparam logic [64:0]   P65      = {1'b0, P_GOLDILOCKS};

  logic [63:0] x_c;
  logic [63:0] t_c;

  modcanon u_canon_x (.a(x_i), .y(x_c));
  modcanon u_canon_t (.a(t_i), .y(t_c));

  // Data taps carry no reset; only the valid bits must be cleared.
  logic [63:0]      x_dly [DELAY];
  logic [DELAY-1:0] v_dly;

  always_ff @(posedge clk_i) begin
    if (ce_i) begin
      x_dly[0] <= x_c;
      for (int i = 1; i < DELAY; i++) x_dly[i] <= x_dly[i-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v_dly <= '0;
    end else if (ce_i) begin
      v_dly[0] <= valid_i;
      for (int i = 1; i < DELAY; i++) v_dly[i] <= v_dly[i-1];
    end
  end

  logic [63:0] x1, t1;
  logic        v1;
  sumdiff_t    sd2;
  logic        v2;
  logic [CW-1:0] cnt;

  logic [64:0] s_next, d_next, s_red;
  logic [63:0] y0_next, y1_next;

  always_comb begin
    s_next  = {1'b0, x1} + {1'b0, t1};
    d_next  = {1'b0, x1} - {1'b0, t1};
    s_red   = (sd2.s >= P65) ? sd2.s - P65 : sd2.s;
    y0_next = s_red[63:0];
    // A borrow means x<t; adding P to the wrapped 64-bit difference lands in range.
    y1_next = sd2.d[64] ? sd2.d[63:0] + P_GOLDILOCKS : sd2.d[63:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x1      <= '0;
      t1      <= '0;
      v1      <= 1'b0;
      sd2     <= '0;
      v2      <= 1'b0;
      y0_o    <= '0;
      y1_o    <= '0;
      valid_o <= 1'b0;
      cnt     <= '0;
    end else if (ce_i) begin
      x1      <= x_dly[DELAY-1];
      t1      <= t_c;
      v1      <= v_dly[DELAY-1];
      sd2.s   <= s_next;
      sd2.d   <= d_next;
      v2      <= v1;
      y0_o    <= y0_next;
      y1_o    <= y1_next;
      valid_o <= v2;
      if (valid_o) cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign last_o = valid_o && (cnt == CNT_LAST);

endmodule

// File: tb/tb_bfly_addsub.sv
// Self-checking bench for bfly_addsub with DELAY=10, N_BFLY=4.
module tb_bfly_addsub;

  localparam int D = 10;
  localparam int NB = 4;
  localparam logic [63:0]  P    = 64'hFFFF_FFFF_0000_0001;
  localparam logic [127:0] P128 = {64'd0, 64'hFFFF_FFFF_0000_0001};

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        ce_i = 1'b0;
  logic        valid_i = 1'b0;
  logic [63:0] x_i = '0;
  logic [63:0] t_i = '0;
  logic [63:0] y0_o, y1_o;
  logic        valid_o, last_o;

  int n_checks = 0;
  int n_pass   = 0;

  bfly_addsub #(.DELAY(D), .N_BFLY(NB)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .ce_i(ce_i), .valid_i(valid_i),
    .x_i(x_i), .t_i(t_i), .y0_o(y0_o), .y1_o(y1_o),
    .valid_o(valid_o), .last_o(last_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference history indexed by enabled-edge number since reset.
  logic [63:0] xs [0:4095];
  logic [63:0] ts [0:4095];
  bit          vs [0:4095];
  logic [63:0] t_sched [0:4127];
  int eidx   = 0;
  int nvalid = 0;

  function automatic logic [127:0] canon(input logic [63:0] v);
    return (v >= P) ? {64'd0, v - P} : {64'd0, v};
  endfunction

  function automatic bit m_valid();
    int k;
    k = eidx - 3 - D;
    return (k >= 0) ? vs[k] : 1'b0;
  endfunction

  function automatic bit m_last();
    return m_valid() && ((nvalid % NB) == NB - 1);
  endfunction

  function automatic logic [63:0] m_y0();
    logic [127:0] r;
    r = (canon(xs[eidx-3-D]) + canon(ts[eidx-3])) % P128;
    return r[63:0];
  endfunction

  function automatic logic [63:0] m_y1();
    logic [127:0] r;
    r = (canon(xs[eidx-3-D]) + P128 - canon(ts[eidx-3])) % P128;
    return r[63:0];
  endfunction

  function automatic logic [63:0] rand64();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0: r = P + 64'($urandom_range(0, 100));
      1: r = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 100));
      2: r = P - 64'd1 - 64'($urandom_range(0, 100));
      3: r = 64'($urandom_range(0, 100));
      default: ;
    endcase
    return r;
  endfunction

  task automatic model_clear();
    eidx = 0;
    nvalid = 0;
    for (int i = 0; i < 4128; i++) t_sched[i] = '0;
  endtask

  // x is paired with the t handed in here, which is presented D enabled edges later.
  task automatic step(input bit ce, input bit v, input logic [63:0] x, input logic [63:0] t);
    ce_i = ce; valid_i = v; x_i = x; t_i = t_sched[eidx];
    if (ce) t_sched[eidx + D] = t;
    @(posedge clk_i);
    if (ce) begin
      if (m_valid()) nvalid++;
      xs[eidx] = x; ts[eidx] = t_i; vs[eidx] = v;
      eidx++;
    end
    #1;
  endtask

  task automatic apply_reset();
    ce_i = 1'b0; valid_i = 1'b0;
    #3 rst_i = 1'b1;
    @(posedge clk_i);
    #2 rst_i = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    #2;
    n_checks++; if (valid_o !== 1'b0) $display("FAIL reset valid_o: got %b want 0", valid_o); else n_pass++;
    n_checks++; if (last_o !== 1'b0) $display("FAIL reset last_o: got %b want 0", last_o); else n_pass++;
    n_checks++; if (y0_o !== 64'd0) $display("FAIL reset y0_o: got %h want 0", y0_o); else n_pass++;
    n_checks++; if (y1_o !== 64'd0) $display("FAIL reset y1_o: got %h want 0", y1_o); else n_pass++;
    apply_reset();
  endtask

  task automatic test_directed();
    logic [63:0] xl [3];
    logic [63:0] tl [3];
    logic [63:0] e0 [3];
    logic [63:0] e1 [3];
    int seen;
    xl[0] = 64'd0;                  tl[0] = 64'd1;
    xl[1] = 64'hFFFFFFFF00000000;   tl[1] = 64'hFFFFFFFF00000000;
    xl[2] = 64'd5;                  tl[2] = 64'hFFFFFFFFFFFFFFFF;
    e0[0] = 64'd1;                  e1[0] = 64'hFFFFFFFF00000000;
    e0[1] = 64'hFFFFFFFEFFFFFFFF;   e1[1] = 64'd0;
    e0[2] = 64'h100000003;          e1[2] = 64'hFFFFFFFE00000008;
    seen = 0;
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      if (i < 3) step(1'b1, 1'b1, xl[i], tl[i]);
      else       step(1'b1, 1'b0, rand64(), rand64());
      n_checks++; if (valid_o !== m_valid()) $display("FAIL dir valid_o: got %b want %b edge %0d", valid_o, m_valid(), eidx); else n_pass++;
      if (valid_o === 1'b1 && seen < 3) begin
        if (seen == 0) begin
          n_checks++; if (eidx !== D + 3) $display("FAIL dir latency: got %0d want %0d", eidx, D + 3); else n_pass++;
        end
        n_checks++; if (y0_o !== e0[seen]) $display("FAIL dir y0 #%0d: got %h want %h", seen, y0_o, e0[seen]); else n_pass++;
        n_checks++; if (y1_o !== e1[seen]) $display("FAIL dir y1 #%0d: got %h want %h", seen, y1_o, e1[seen]); else n_pass++;
        seen++;
      end
    end
    n_checks++; if (seen !== 3) $display("FAIL dir outputs: got %0d want 3", seen); else n_pass++;
  endtask

  task automatic test_ce_stall();
    int beats;
    beats = 0;
    apply_reset();
    for (int i = 0; i < 55; i++) begin
      if (ce_i === 1'b1 && valid_o === 1'b1) beats++;
      if (i >= 20 && i < 27)  step(1'b0, 1'b1, rand64(), rand64());
      else if (i < 40)        step(1'b1, 1'b1, rand64(), rand64());
      else                    step(1'b1, 1'b0, rand64(), rand64());
      n_checks++; if (valid_o !== m_valid()) $display("FAIL stall valid_o: got %b want %b step %0d", valid_o, m_valid(), i); else n_pass++;
      n_checks++; if (last_o !== m_last()) $display("FAIL stall last_o: got %b want %b step %0d", last_o, m_last(), i); else n_pass++;
      if (m_valid()) begin
        n_checks++; if (y0_o !== m_y0()) $display("FAIL stall y0: got %h want %h step %0d", y0_o, m_y0(), i); else n_pass++;
        n_checks++; if (y1_o !== m_y1()) $display("FAIL stall y1: got %h want %h step %0d", y1_o, m_y1(), i); else n_pass++;
      end
    end
    n_checks++; if (beats !== 33) $display("FAIL stall beats: got %0d want 33", beats); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int k, lasts;
    k = 0; lasts = 0;
    apply_reset();
    for (int i = 0; i < 24; i++) begin
      step(1'b1, i < 10, rand64(), rand64());
      if (valid_o === 1'b1) begin
        k++;
        n_checks++; if (last_o !== (k == 4 || k == 8)) $display("FAIL b2b last_o at output %0d: got %b want %b", k, last_o, (k == 4 || k == 8)); else n_pass++;
      end
    end
    n_checks++; if (k !== 10) $display("FAIL b2b outputs: got %0d want 10", k); else n_pass++;
    // Counter now sits at 2, so the second of two more outputs closes the frame.
    k = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, i < 2, rand64(), rand64());
      if (valid_o === 1'b1) begin
        k++;
        if (last_o === 1'b1) lasts++;
        n_checks++; if (last_o !== (k == 2)) $display("FAIL b2b wrap last_o at output %0d: got %b want %b", k, last_o, (k == 2)); else n_pass++;
      end
    end
    n_checks++; if (lasts !== 1) $display("FAIL b2b wrap lasts: got %0d want 1", lasts); else n_pass++;
  endtask

  task automatic test_async_reset();
    int lasts, k;
    lasts = 0; k = 0;
    apply_reset();
    for (int i = 0; i < 17; i++) step(1'b1, i < 11, rand64(), rand64());
    n_checks++; if (valid_o !== 1'b1) $display("FAIL arst pre valid_o: got %b want 1", valid_o); else n_pass++;
    #3 rst_i = 1'b1;
    #1;
    n_checks++; if (valid_o !== 1'b0) $display("FAIL arst valid_o: got %b want 0", valid_o); else n_pass++;
    n_checks++; if (last_o !== 1'b0) $display("FAIL arst last_o: got %b want 0", last_o); else n_pass++;
    n_checks++; if (y0_o !== 64'd0) $display("FAIL arst y0_o: got %h want 0", y0_o); else n_pass++;
    n_checks++; if (y1_o !== 64'd0) $display("FAIL arst y1_o: got %h want 0", y1_o); else n_pass++;
    @(posedge clk_i);
    #2 rst_i = 1'b0;
    model_clear();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, rand64(), rand64());
      n_checks++; if (valid_o !== 1'b0) $display("FAIL arst stale valid_o: got %b want 0 step %0d", valid_o, i); else n_pass++;
    end
    for (int i = 0; i < 18; i++) begin
      step(1'b1, i < 4, rand64(), rand64());
      n_checks++; if (valid_o !== m_valid()) $display("FAIL arst post valid_o: got %b want %b step %0d", valid_o, m_valid(), i); else n_pass++;
      if (valid_o === 1'b1) begin
        k++;
        if (last_o === 1'b1) lasts++;
        n_checks++; if (last_o !== (k == 4)) $display("FAIL arst post last_o at output %0d: got %b want %b", k, last_o, (k == 4)); else n_pass++;
        n_checks++; if (y0_o !== m_y0()) $display("FAIL arst post y0: got %h want %h", y0_o, m_y0()); else n_pass++;
      end
    end
    n_checks++; if (lasts !== 1) $display("FAIL arst post lasts: got %0d want 1", lasts); else n_pass++;
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 420; i++) begin
      if (i < 400) step($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, rand64(), rand64());
      else         step(1'b1, 1'b0, rand64(), rand64());
      n_checks++; if (valid_o !== m_valid()) $display("FAIL rand valid_o: got %b want %b step %0d", valid_o, m_valid(), i); else n_pass++;
      n_checks++; if (last_o !== m_last()) $display("FAIL rand last_o: got %b want %b step %0d", last_o, m_last(), i); else n_pass++;
      if (m_valid()) begin
        n_checks++; if (y0_o !== m_y0()) $display("FAIL rand y0: got %h want %h step %0d", y0_o, m_y0(), i); else n_pass++;
        n_checks++; if (y1_o !== m_y1()) $display("FAIL rand y1: got %h want %h step %0d", y1_o, m_y1(), i); else n_pass++;
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_directed();
    test_ce_stall();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
